// File: rtl/io_timer_mc.sv
// io_timer_mc: prescaled up-counter with CChNum compare channels, per-channel
// flags and interrupt enables, behind a 16-byte IO register window.
// Channel 0 sets the counting period; an optional one-shot mode stops the
// counter after the first period match.
module io_timer_mc #(
  parameter logic [15:0] CAddrBase = 16'h0000,
  parameter int          CWidth    = 16,
  parameter int          CChNum    = 2
) (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AClkHEn,
  input  logic [15:0] AIoAddr,
  input  logic [63:0] AIoMosi,
  output logic [63:0] AIoMiso,
  input  logic [3:0]  AIoWrSize,
  input  logic [3:0]  AIoRdSize,
  output logic        AIoAddrAck,
  output logic        AIoAddrErr,
  input  logic        ASync1M,
  input  logic        ASync1K,
  output logic        AIrq,
  output logic [7:0]  ATest
);

  // Access size required by the counter-width registers (Cmp, Counter).
  localparam logic [3:0] CSzCnt = (CWidth == 32) ? 4'b0100 : 4'b0010;

  // Architectural state.
  logic [7:0]        ctrl_q, ctrl_d;
  logic [CChNum-1:0] irqen_q, irqen_d;
  logic [CChNum-1:0] flags_q, flags_d;
  logic [7:0]        presc_q, presc_d;
  logic [CWidth-1:0] cmp_q [CChNum];
  logic [CWidth-1:0] cmp_d [CChNum];
  logic [CWidth-1:0] cnt_q, cnt_d;
  logic [7:0]        fpresc_q, fpresc_d;
  logic              irq_q, irq_d;

  // Decode and datapath helpers.
  logic [15:0]       off;
  logic              win;
  logic              mapped;
  logic [3:0]        req_sz;
  logic [3:0]        acc_sz;
  logic              wr_ok, rd_ok;
  logic              wr_ctrl, wr_irqen, wr_flags, wr_presc, wr_cnt;
  logic [CChNum-1:0] wr_cmp;
  logic [1:0]        src;
  logic              tick;
  logic              inc_en;
  logic [CChNum-1:0] match;
  logic              unused_bits;

  assign off    = AIoAddr - CAddrBase;
  assign win    = (off[15:4] == 12'h000);
  assign acc_sz = AIoWrSize | AIoRdSize;
  assign src    = ctrl_q[5:4];

  // Upper write-data bits beyond the counter width are never consumed.
  assign unused_bits = ^AIoMosi[63:CWidth];

  // Address decode: which offsets exist and which access size each one takes.
  always_comb begin
    mapped = 1'b0;
    req_sz = 4'b0001;
    if (win) begin
      case (off[3:0])
        4'h0, 4'h1, 4'h2, 4'h3: mapped = 1'b1;
        4'h8: begin
          mapped = 1'b1;
          req_sz = CSzCnt;
        end
        default: ;
      endcase
      for (int k = 0; k < CChNum; k++) begin
        if (off[3:0] == 4'(4 + k)) begin
          mapped = 1'b1;
          req_sz = CSzCnt;
        end
      end
    end
  end

  assign AIoAddrAck = mapped & (acc_sz != 4'b0000) & (acc_sz == req_sz);
  assign AIoAddrErr = mapped & (acc_sz != 4'b0000) & (acc_sz != req_sz);
  assign wr_ok      = AIoAddrAck & (AIoWrSize != 4'b0000);
  assign rd_ok      = AIoAddrAck & (AIoRdSize != 4'b0000);

  // Per-register write strobes; a mis-sized access never produces one.
  always_comb begin
    wr_ctrl  = wr_ok & (off[3:0] == 4'h0);
    wr_irqen = wr_ok & (off[3:0] == 4'h1);
    wr_flags = wr_ok & (off[3:0] == 4'h2);
    wr_presc = wr_ok & (off[3:0] == 4'h3);
    wr_cnt   = wr_ok & (off[3:0] == 4'h8);
    wr_cmp   = '0;
    for (int k = 0; k < CChNum; k++) begin
      wr_cmp[k] = wr_ok & (off[3:0] == 4'(4 + k));
    end
  end

  // Tick source select, prescaler terminal count and channel matches.
  always_comb begin
    case (src)
      2'b11:   tick = AClkHEn;
      2'b10:   tick = ASync1M;
      2'b01:   tick = ASync1K;
      default: tick = 1'b0;
    endcase
    inc_en = tick & (fpresc_q == presc_q);
    for (int k = 0; k < CChNum; k++) begin
      match[k] = inc_en & (cnt_q == cmp_q[k]);
    end
  end

  // Next-state: counter, prescaler, control, flags and interrupt.
  always_comb begin
    ctrl_d   = ctrl_q;
    irqen_d  = irqen_q;
    presc_d  = presc_q;
    cmp_d    = cmp_q;
    cnt_d    = cnt_q;
    fpresc_d = fpresc_q;

    // A Ctrl write wins over the one-shot stop in the same cycle.
    if (wr_ctrl) begin
      ctrl_d = AIoMosi[7:0];
    end else if (ctrl_q[3] && match[0]) begin
      ctrl_d = ctrl_q & 8'hCF;
    end

    if (wr_irqen) irqen_d = AIoMosi[CChNum-1:0];
    if (wr_presc) presc_d = AIoMosi[7:0];
    for (int k = 0; k < CChNum; k++) begin
      if (wr_cmp[k]) cmp_d[k] = AIoMosi[CWidth-1:0];
    end

    // Source off holds everything at zero; a counter load beats the period
    // reset and the increment.
    if (src == 2'b00) begin
      cnt_d    = '0;
      fpresc_d = '0;
    end else if (wr_cnt) begin
      cnt_d    = AIoMosi[CWidth-1:0];
      fpresc_d = '0;
    end else begin
      if (match[0]) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CWidth'(inc_en);
      end
      if (tick) begin
        fpresc_d = inc_en ? 8'h00 : fpresc_q + 8'h01;
      end
    end

    // A match set beats a write-one-to-clear on the same flag.
    flags_d = (flags_q & ~(wr_flags ? AIoMosi[CChNum-1:0] : '0)) | match;
    irq_d   = |(flags_d & irqen_d);
  end

  // State registers with asynchronous reset and clock enable.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      ctrl_q   <= '0;
      irqen_q  <= '0;
      flags_q  <= '0;
      presc_q  <= '0;
      cnt_q    <= '0;
      fpresc_q <= '0;
      irq_q    <= 1'b0;
      for (int k = 0; k < CChNum; k++) cmp_q[k] <= '0;
    end else if (AClkHEn) begin
      ctrl_q   <= ctrl_d;
      irqen_q  <= irqen_d;
      flags_q  <= flags_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      fpresc_q <= fpresc_d;
      irq_q    <= irq_d;
      for (int k = 0; k < CChNum; k++) cmp_q[k] <= cmp_d[k];
    end
  end

  // Read-data mux; zero unless a correctly sized read hits a register.
  always_comb begin
    AIoMiso = '0;
    if (rd_ok) begin
      case (off[3:0])
        4'h0:    AIoMiso = 64'(ctrl_q);
        4'h1:    AIoMiso = 64'(irqen_q);
        4'h2:    AIoMiso = 64'(flags_q);
        4'h3:    AIoMiso = 64'(presc_q);
        4'h8:    AIoMiso = 64'(cnt_q);
        default: ;
      endcase
      for (int k = 0; k < CChNum; k++) begin
        if (off[3:0] == 4'(4 + k)) AIoMiso = 64'(cmp_q[k]);
      end
    end
  end

  assign AIrq  = irq_q;
  assign ATest = {AClkH, (src != 2'b00), inc_en, match[0], flags_q[0],
                  irq_d, irq_q, ctrl_q[3]};

endmodule

// File: doc/io_timer_mc.md
IO_TIMER_MC -- requirements
Module: io_timer_mc

Interface
REQ-001 SHALL have parameter CAddrBase, default 16'h0000: base of the 16-byte register window.
REQ-002 SHALL have parameter CWidth, default 16: counter, compare and prescaler-output width; legal values are 16 or 32.
REQ-003 SHALL have parameter CChNum, default 2: number of compare channels; legal range 1..4.
REQ-004 AClkH  in  1  clock; all state updates on the rising edge.
REQ-005 AResetH  in  1  reset, asynchronous, active-high.
REQ-006 AClkHEn  in  1  clock enable; when 0, all state SHALL hold.
REQ-007 AIoAddr  in  16  IO byte address.
REQ-008 AIoMosi  in  64  write data, right-aligned.
REQ-009 AIoMiso  out  64  read data, right-aligned; 0 when no read hits.
REQ-010 AIoWrSize, AIoRdSize  in  4 each  one-hot access size: bit0 = byte, bit1 = word, bit2 = dword, bit3 = qword; all zero means no access.
REQ-011 AIoAddrAck, AIoAddrErr  out  1 each  address hit with legal size / address hit with illegal size.
REQ-012 ASync1M, ASync1K  in  1 each  single-cycle tick strobes.
REQ-013 AIrq  out  1  registered interrupt request.
REQ-014 ATest  out  8  debug: {AClkH, src!=0, BIncEn, ch0 match, flag0, IRQ next, AIrq, one-shot}.

Function
REQ-015 Register map (offset, size, meaning):
- +0, byte, Ctrl: [5:4] Src (11 = CLK, 10 = 1M, 01 = 1K, 00 = off), [3] OneShot, others RFU; read returns the stored value.
- +1, byte, IrqEn: bit k enables channel k.
- +2, byte, Flags: read returns flags; writing 1 to bit k clears flag k.
- +3, byte, Presc: prescaler reload value.
- +4+k, CWidth/8 bytes (word or dword), Cmp[k] for k < CChNum: read/write.
- +8, CWidth/8 bytes, Counter: read returns counter; write loads it.
REQ-016 Ack SHALL assert only when the offset is mapped and the size matches; Err SHALL assert when the offset is mapped and the size mismatches; an Err access SHALL have no effect.
REQ-017 Tick SHALL be 1 every enabled cycle for Src=11, ASync1M for Src=10, ASync1K for Src=01, and 0 for Src=00.
REQ-018 Prescaler: on a tick, if FPresc==Presc then BIncEn=1 and FPresc←0, else FPresc←FPresc+1; increment rate is tick/(Presc+1).
REQ-019 Src=00 SHALL force the counter and FPresc to 0 every cycle.
REQ-020 Match k SHALL be (Counter==Cmp[k]) & BIncEn, evaluated on the pre-update counter.
REQ-021 Channel 0 SHALL define the period: on match 0, Counter←0, else Counter←Counter+BIncEn; wrap modulo 2^CWidth.
REQ-022 Match k SHALL set Flags[k] on the next edge; when a set and a W1C on the same flag occur in the same cycle, the set SHALL win.
REQ-023 When OneShot=1 and match 0 occurs, Src SHALL be cleared to 00 on the same edge; the counter reads 0 afterwards.
REQ-024 A Counter write SHALL load AIoMosi[CWidth-1:0] and clear FPresc; the write SHALL override increment and period reset; matches in that cycle still set flags.
REQ-025 A Ctrl write SHALL override the one-shot clear in the same cycle.
REQ-026 AIrq SHALL be registered |(nextFlags & IrqEn), asserting on the same edge the flag sets, and deasserting on the edge after the W1C or the IrqEn clear.
REQ-027 Flags and IrqEn bits for k ≥ CChNum SHALL read 0 and ignore writes.

Reset
REQ-028 Asserting AResetH SHALL immediately set Ctrl, IrqEn, Flags, Presc, all Cmp, Counter, FPresc and AIrq to 0, independent of AClkH.
REQ-029 After release, the block SHALL be idle (Src=00) and AIoMiso SHALL be 0 with no read hit.
REQ-030 Reset mid-count or with a pending IRQ SHALL lose all state, with no residual IRQ.

Verification
REQ-031 Src=11, Presc=0, Cmp0=4 → Counter sequence 0,1,2,3,4,0,…; Flags[0] sets every 5 cycles.
REQ-032 Src=11, Presc=2, Cmp0=1 → counter increments every 3rd cycle; Flags[0] sets 6 cycles after start.
REQ-033 CChNum=2, Cmp0=10, Cmp1=3, IrqEn=2'b10 → Flags[1] set and AIrq=1 at count 3; Flags[0] set at 10 with no IRQ contribution; W1C 0x02 → AIrq=0 on the next edge.
REQ-034 OneShot=1, Src=11, Cmp0=2 → after match, Ctrl reads 0x08 and the counter stays 0.
REQ-035 W1C on Flags[0] in the same cycle as match 0 → Flags[0] remains 1; a word write to +0 → Err=1 and no state change.
REQ-036 AResetH pulse asserted between clock edges with AIrq=1 → AIrq=0 and all registers 0 before the next edge.
